// File: rtl/fifo_wptr_ctrl_if.sv
// Write-side bundle between the write requester / sync-flop pair and fifo_wptr_ctrl.
// The controller uses the slave view. The requester or testbench uses the master view.
interface fifo_wptr_ctrl_if #(
    parameter int unsigned ADDR_WIDTH = 3
);
    logic                  w_en;
    logic [ADDR_WIDTH:0]   wq2_rptr;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [ADDR_WIDTH:0]   wptr;
    logic                  full;
    logic                  almost_full;
    logic [ADDR_WIDTH:0]   wr_count;
    logic                  wr_ack;
    logic                  overflow;

    modport master (
        output w_en, wq2_rptr,
        input  waddr, wptr, full, almost_full, wr_count, wr_ack, overflow
    );

    modport slave (
        input  w_en, wq2_rptr,
        output waddr, wptr, full, almost_full, wr_count, wr_ack, overflow
    );
endinterface

// File: rtl/fifo_wptr_ctrl.sv
// Async-FIFO write-side pointer/flag controller.
// It produces the Gray write pointer and full, almost-full, occupancy and overflow status against the synchronized read pointer.
module fifo_wptr_ctrl #(
    parameter int unsigned ADDR_WIDTH   = 3,
    parameter int unsigned AFULL_THRESH = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    fifo_wptr_ctrl_if.slave  wif
);
    localparam int unsigned    PW   = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]  AF_T = PW'(AFULL_THRESH);

    logic [PW-1:0] wbin_q, wbin_d;
    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] wr_count_q, wr_count_d;
    logic [PW-1:0] rbin;
    logic          full_q, full_d;
    logic          afull_q, afull_d;
    logic          ack_q, ack_d;
    logic          ovf_q, ovf_d;
    logic          push;

    // Each binary bit j is the XOR of Gray bits j and above.
    // This gives the same result as the MSB-down XOR chain.
    always_comb begin
        rbin = '0;
        for (int unsigned j = 0; j < PW; j++) begin
            rbin[j] = ^(wif.wq2_rptr >> j);
        end
    end

    always_comb begin
        push       = wif.w_en & ~full_q;
        wbin_d     = wbin_q + {{ADDR_WIDTH{1'b0}}, push};
        wptr_d     = wbin_d ^ (wbin_d >> 1);
        wr_count_d = wbin_d - rbin;
        // Full when the Gray pointers differ only in their top two bits.
        full_d     = (wptr_d == {~wif.wq2_rptr[PW-1:PW-2], wif.wq2_rptr[PW-3:0]});
        afull_d    = (wr_count_d >= AF_T);
        ack_d      = push;
        ovf_d      = ovf_q | (wif.w_en & full_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wbin_q     <= '0;
            wptr_q     <= '0;
            wr_count_q <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            ack_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            wbin_q     <= wbin_d;
            wptr_q     <= wptr_d;
            wr_count_q <= wr_count_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            ack_q      <= ack_d;
            ovf_q      <= ovf_d;
        end
    end

    assign wif.waddr       = wbin_q[ADDR_WIDTH-1:0];
    assign wif.wptr        = wptr_q;
    assign wif.full        = full_q;
    assign wif.almost_full = afull_q;
    assign wif.wr_count    = wr_count_q;
    assign wif.wr_ack      = ack_q;
    assign wif.overflow    = ovf_q;
endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Self-checking bench for fifo_wptr_ctrl.
// It runs directed scenarios and then random pushes and reads against an arithmetic occupancy model.
module tb_fifo_wptr_ctrl;
    localparam int unsigned AW  = 3;
    localparam int unsigned AFT = 6;
    localparam int unsigned D   = 1 << AW;
    localparam int unsigned M   = 1 << (AW + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wptr_ctrl_if #(.ADDR_WIDTH(AW)) wif ();

    fifo_wptr_ctrl #(
        .ADDR_WIDTH  (AW),
        .AFULL_THRESH(AFT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .wif  (wif)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // The model tracks the count of accepted pushes and derives status from occupancy arithmetic.
    int unsigned m_wb  = 0;
    int unsigned m_cnt = 0;
    bit          m_full, m_af, m_ack, m_ovf;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int unsigned bin2gray(input int unsigned b);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned gray2bin(input int unsigned g);
        int unsigned b = 0;
        for (int k = 0; k < 32; k++) b = b ^ (g >> k);
        return b;
    endfunction

    task automatic model_reset();
        m_wb = 0; m_cnt = 0;
        m_full = 0; m_af = 0; m_ack = 0; m_ovf = 0;
    endtask

    task automatic model_edge();
        bit push;
        int unsigned rb;
        push  = wif.w_en && !m_full;
        m_ovf = m_ovf || (wif.w_en && m_full);
        m_wb  = (m_wb + push) % M;
        rb    = gray2bin(wif.wq2_rptr);
        m_cnt = (m_wb + M - rb) % M;
        m_full = (m_cnt == D);
        m_af   = (m_cnt >= AFT);
        m_ack  = push;
    endtask

    task automatic check_all();
        check_eq("waddr",       wif.waddr,       m_wb % D);
        check_eq("wptr",        wif.wptr,        bin2gray(m_wb));
        check_eq("full",        wif.full,        m_full);
        check_eq("almost_full", wif.almost_full, m_af);
        check_eq("wr_count",    wif.wr_count,    m_cnt);
        check_eq("wr_ack",      wif.wr_ack,      m_ack);
        check_eq("overflow",    wif.overflow,    m_ovf);
    endtask

    // Inputs are stable here, so the model consumes them before the edge and the DUT is sampled 1 ns after it.
    task automatic step();
        if (rst_n) model_edge();
        else       model_reset();
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int unsigned gtab [8];
        logic [AW:0] lag1, lag2, prevp, cur;
        bit          saw_wrap;
        int unsigned rr, avail, adv;

        gtab = '{1, 3, 2, 6, 7, 5, 4, 12};
        wif.w_en     = 1'b0;
        wif.wq2_rptr = '0;
        model_reset();

        // Reset held with w_en toggling.
        for (int i = 0; i < 4; i++) begin
            wif.w_en = 1'(i);
            step();
        end
        @(negedge clk) rst_n = 1'b1;
        wif.w_en = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Fill eight slots with the read pointer at zero.
        for (int i = 0; i < 8; i++) begin
            check_eq("fill_waddr", wif.waddr, i);
            wif.w_en = 1'b1;
            step();
            check_eq("fill_wptr", wif.wptr, gtab[i]);
            if (i == 5) check_eq("fill_afull6", wif.almost_full, 1);
        end
        check_eq("fill_full", wif.full, 1);
        check_eq("fill_count", wif.wr_count, 8);

        // Writes while full are rejected.
        for (int i = 0; i < 2; i++) begin
            wif.w_en = 1'b1;
            step();
            check_eq("ovf_waddr", wif.waddr, 0);
            check_eq("ovf_wptr", wif.wptr, 4'b1100);
            check_eq("ovf_ack", wif.wr_ack, 0);
            check_eq("ovf_flag", wif.overflow, 1);
        end
        wif.w_en = 1'b0;
        step();
        check_eq("ovf_sticky", wif.overflow, 1);

        // The reader advances to 4.
        wif.wq2_rptr = 4'b0110;
        step();
        check_eq("drain_full", wif.full, 0);
        check_eq("drain_count", wif.wr_count, 4);
        check_eq("drain_afull", wif.almost_full, 0);
        check_eq("drain_waddr", wif.waddr, 0);
        wif.w_en = 1'b1;
        step();
        check_eq("drain_wptr", wif.wptr, 4'b1101);

        // The read pointer trails wptr by two edges across the wrap.
        lag1 = wif.wptr; lag2 = wif.wptr; prevp = wif.wptr;
        saw_wrap = 0;
        for (int i = 0; i < 20; i++) begin
            wif.wq2_rptr = lag2;
            wif.w_en     = 1'b1;
            step();
            cur = wif.wptr;
            if (cur != prevp) check_eq("wrap_hamming", $countones(cur ^ prevp), 1);
            check_eq("wrap_nofull", wif.full, 0);
            check_eq("wrap_cnt_le3", (wif.wr_count <= 3), 1);
            if (prevp == 4'b1000 && cur == 4'b0000) saw_wrap = 1;
            lag2 = lag1; lag1 = cur; prevp = cur;
        end
        check_eq("wrap_seen", saw_wrap, 1);

        // Random phase: slow reads first so the FIFO fills, then faster reads.
        rr = gray2bin(wif.wq2_rptr);
        for (int i = 0; i < 400; i++) begin
            wif.w_en = ($urandom_range(0, 3) != 0);
            avail = (m_wb + M - rr) % M;
            adv   = (i < 200) ? (($urandom_range(0, 3) == 0) ? 1 : 0) : $urandom_range(0, 2);
            if (adv > avail) adv = avail;
            rr = (rr + adv) % M;
            wif.wq2_rptr = (AW + 1)'(bin2gray(rr));
            step();
            if (i > 0 && wif.wptr != prevp)
                check_eq("rand_hamming", $countones(wif.wptr ^ prevp), 1);
            prevp = wif.wptr;
        end

        // Asynchronous reset dropped between edges in the middle of a burst.
        wif.w_en = 1'b1;
        for (int i = 0; i < 5; i++) step();
        #3 rst_n = 1'b0;
        #1;
        check_eq("arst_waddr", wif.waddr, 0);
        check_eq("arst_wptr", wif.wptr, 0);
        check_eq("arst_full", wif.full, 0);
        check_eq("arst_afull", wif.almost_full, 0);
        check_eq("arst_count", wif.wr_count, 0);
        check_eq("arst_ack", wif.wr_ack, 0);
        check_eq("arst_ovf", wif.overflow, 0);
        model_reset();
        wif.wq2_rptr = '0;
        step();
        @(negedge clk) rst_n = 1'b1;
        check_eq("post_arst_waddr", wif.waddr, 0);
        step();
        check_eq("post_arst_wptr", wif.wptr, 1);
        check_eq("post_arst_ack", wif.wr_ack, 1);
        wif.w_en = 1'b0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
